sparse_vec_encoder: RTL and testbench
=====================================

SPARSE_VEC_ENCODER -- requirements
Module: sparse_vec_encoder

Interface
REQ-001 SHALL have parameter VEC_LEN, default 8, maximum elements per vector (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, element width.
REQ-003 SHALL have parameter IDX_W, default 3, index width, equal to log2(VEC_LEN).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  design enable; low freezes all state.
REQ-007 SHALL have port in_data  input  DATA_W  dense activation element.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_last  input  1  marks final element of vector.
REQ-010 SHALL have port in_ready  output  1  encoder accepts element.
REQ-011 SHALL have port out_value  output  DATA_W  nonzero element value to MVM stage.
REQ-012 SHALL have port out_index  output  IDX_W  position of out_value in vector.
REQ-013 SHALL have port out_valid  output  1  out_value/out_index valid.
REQ-014 SHALL have port out_last  output  1  final nonzero element of vector.
REQ-015 SHALL have port out_ready  input  1  downstream MVM accepts beat.
REQ-016 SHALL have port vec_done  output  1  one-cycle pulse, vector fully emitted.
REQ-017 SHALL have port nz_count  output  IDX_W+1  nonzero count of vector in flight or last vector.

Function
REQ-018 SHALL implement states LOAD and EMIT.
REQ-019 LOAD: in_ready=1, out_valid=0; element accepted when in_valid&in_ready&ena.
REQ-020 Accepted element SHALL be stored at wr_ptr, nz_mask[wr_ptr] set iff element nonzero, wr_ptr incremented.
REQ-021 nz_count SHALL be cleared on first element of a vector and incremented per nonzero element accepted.
REQ-022 LOAD->EMIT SHALL occur on accept with in_last=1 or on accept at wr_ptr=VEC_LEN-1 (implicit last, in_last ignored).
REQ-023 If the completed vector has nz_mask=0, SHALL return to LOAD instead of EMIT and pulse vec_done the next cycle.
REQ-024 EMIT: in_ready=0, out_valid=1; out_index = lowest set bit of remaining mask, out_value = stored element at that index, registered, first beat the cycle after last accept.
REQ-025 Zero elements SHALL consume no cycles; consecutive beats at one per cycle when out_ready held high.
REQ-026 out_last SHALL be 1 iff exactly one bit remains in the remaining mask.
REQ-027 Handshake: out_value, out_index, out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 On out_valid&out_ready&ena, SHALL clear emitted bit; after the out_last beat, SHALL return to LOAD, clear wr_ptr, pulse vec_done the following cycle.
REQ-029 in_ready SHALL be 1 in the cycle after the out_last handshake (back-to-back vectors, no bubble beyond one cycle).
REQ-030 ena=0 SHALL force in_ready=0 and out_valid=0 and hold all registers; outputs resume unchanged when ena returns high.
REQ-031 nz_count SHALL hold its value through EMIT and until the next vector's first accept.

Reset
REQ-032 rst_n=0 SHALL immediately, asynchronously set state=LOAD, wr_ptr=0, nz_mask=0, nz_count=0, out_valid=0, out_last=0, out_value=0, out_index=0, vec_done=0; in_ready=1 after release when ena=1.
REQ-033 Reset mid-EMIT SHALL discard the vector; no beat or vec_done SHALL follow release.

Verification
REQ-034 Vector [0,5,0,0,9,0,0,3] in_last on 8th, out_ready=1 -> beats (1,5),(4,9),(7,3) on three consecutive cycles, out_last on (7,3), nz_count=3, vec_done one cycle later.
REQ-035 Vector [0,0,0,0] with in_last on 4th -> no out_valid, vec_done pulse, nz_count=0, in_ready high next cycle.
REQ-036 Vector [7,8] in_last, out_ready low 3 cycles on first beat -> (0,7) held stable 3 cycles, then (1,8) out_last.
REQ-037 Eight nonzero elements 1..8, in_last never asserted -> implicit last at 8th, indices 0..7 emitted, nz_count=8.
REQ-038 ena dropped during EMIT after first beat of [0,4,6] -> out_valid=0 while low, (2,6) presented on re-enable, no beat lost or duplicated.
REQ-039 rst_n pulsed low during EMIT of [1,2,3] -> all outputs zero immediately, next vector [0,9] emits only (1,9).

Source files
------------

// File: rtl/sparse_vec_encoder_if.sv
// Stream bundle between a dense activation source, the sparse encoder and the MVM stage.
// The master modport drives elements in and accepts beats out; the slave modport is the encoder.
interface sparse_vec_encoder_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 3
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] out_value;
    logic [IDX_W-1:0]  out_index;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              vec_done;
    logic [IDX_W:0]    nz_count;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_value, out_index, out_valid, out_last, vec_done, nz_count
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_value, out_index, out_valid, out_last, vec_done, nz_count
    );
endinterface

// File: rtl/sparse_vec_encoder.sv
// Collects a dense vector, then streams only its nonzero elements as (index, value) beats,
// lowest index first, one beat per cycle while the consumer is ready.
module sparse_vec_encoder #(
    parameter int VEC_LEN = 8,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    sparse_vec_encoder_if.slave  s_if
);
    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_mem [VEC_LEN];
    logic [IDX_W-1:0]    r_wr_ptr;
    logic [VEC_LEN-1:0]  r_nz_mask;
    logic [IDX_W:0]      r_nz_count;
    logic                r_out_valid;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_value;
    logic [IDX_W-1:0]    r_out_index;
    logic                r_vec_done;

    logic                w_accept;
    logic                w_elem_nz;
    logic                w_first_elem;
    logic                w_vec_end;
    logic                w_fire;
    logic [VEC_LEN-1:0]  w_wr_oh;
    logic [VEC_LEN-1:0]  w_emit_oh;
    logic [VEC_LEN-1:0]  w_load_mask;
    logic [VEC_LEN-1:0]  w_rem_mask;
    logic [VEC_LEN-1:0]  w_src_mask;
    logic [VEC_LEN-1:0]  w_low_oh;
    logic [IDX_W-1:0]    w_src_idx;
    logic [DATA_W-1:0]   w_src_value;
    logic                w_src_any;
    logic                w_src_last;

    assign w_accept     = ena & (r_state == LOAD) & s_if.in_valid;
    assign w_elem_nz    = |s_if.in_data;
    assign w_first_elem = (r_wr_ptr == '0);
    assign w_vec_end    = s_if.in_last | (r_wr_ptr == IDX_W'(VEC_LEN - 1));
    assign w_fire       = ena & r_out_valid & s_if.out_ready;

    // Mask as it will look after the current accept, and after the current beat leaves.
    generate
        for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_mask
            assign w_wr_oh[gi]     = (r_wr_ptr == IDX_W'(gi));
            assign w_emit_oh[gi]   = (r_out_index == IDX_W'(gi));
            assign w_load_mask[gi] = w_wr_oh[gi] ? w_elem_nz : (r_nz_mask[gi] & ~w_first_elem);
            assign w_rem_mask[gi]  = r_nz_mask[gi] & ~w_emit_oh[gi];
        end
    endgenerate

    // One shared picker serves both the first beat (from LOAD) and every following beat.
    assign w_src_mask = (r_state == LOAD) ? w_load_mask : w_rem_mask;
    assign w_low_oh   = w_src_mask & (~w_src_mask + VEC_LEN'(1));
    assign w_src_any  = |w_src_mask;
    assign w_src_last = w_src_any & ~(|(w_src_mask & (w_src_mask - VEC_LEN'(1))));

    always_comb begin
        w_src_idx = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (w_low_oh[i]) begin
                w_src_idx = w_src_idx | IDX_W'(i);
            end
        end
    end

    // The element being written this cycle is not in the array yet, so bypass it.
    assign w_src_value = ((r_state == LOAD) && (w_src_idx == r_wr_ptr)) ? s_if.in_data
                                                                         : r_mem[w_src_idx];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= s_if.in_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD: begin
                if (w_accept && w_vec_end && w_src_any) begin
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                if (w_fire && r_out_last) begin
                    w_state_next = LOAD;
                end
            end
            default: w_state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_nz_mask   <= '0;
            r_nz_count  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_value <= '0;
            r_out_index <= '0;
            r_vec_done  <= 1'b0;
        end else if (ena) begin
            r_vec_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_nz_count <= (w_first_elem ? '0 : r_nz_count)
                                      + {{IDX_W{1'b0}}, w_elem_nz};
                        r_nz_mask  <= w_load_mask;
                        if (w_vec_end) begin
                            r_wr_ptr <= '0;
                            if (w_src_any) begin
                                r_out_valid <= 1'b1;
                                r_out_value <= w_src_value;
                                r_out_index <= w_src_idx;
                                r_out_last  <= w_src_last;
                            end else begin
                                r_vec_done <= 1'b1;
                            end
                        end else begin
                            r_wr_ptr <= r_wr_ptr + IDX_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (w_fire) begin
                        r_nz_mask <= w_rem_mask;
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_vec_done  <= 1'b1;
                            r_wr_ptr    <= '0;
                        end else begin
                            r_out_value <= w_src_value;
                            r_out_index <= w_src_idx;
                            r_out_last  <= w_src_last;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_if.in_ready  = ena & (r_state == LOAD);
    assign s_if.out_valid = ena & r_out_valid;
    assign s_if.out_value = r_out_value;
    assign s_if.out_index = r_out_index;
    assign s_if.out_last  = r_out_last;
    assign s_if.vec_done  = r_vec_done;
    assign s_if.nz_count  = r_nz_count;
endmodule

// File: tb/tb_sparse_vec_encoder.sv
// Scoreboard bench: each issued vector is reduced to its expected nonzero beats and count,
// and an independent monitor checks every beat and vec_done the encoder produces.
module tb_sparse_vec_encoder;
    localparam int VL = 8;
    localparam int DW = 8;
    localparam int IW = 3;

    typedef struct {
        int idx;
        int val;
        int last;
    } beat_t;

    logic clk;
    logic rst_n;
    logic ena;

    sparse_vec_encoder_if #(.DATA_W(DW), .IDX_W(IW)) sif ();

    sparse_vec_encoder #(.VEC_LEN(VL), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .s_if  (sif)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    beat_t exp_q[$];
    int    exp_nz_q[$];
    int    stim[$];
    int    beat_cyc_q[$];
    int    done_cyc = 0;
    int    acc_cyc  = 0;
    bit    rand_rdy = 0;
    bit    rand_ena = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired, got no response, expected one", name);
    endtask

    // Reference: the nonzero elements in index order; the highest one carries last.
    task automatic push_model();
        int nz = 0;
        int seen = 0;
        beat_t b;
        foreach (stim[i]) if (stim[i] != 0) nz++;
        foreach (stim[i]) begin
            if (stim[i] != 0) begin
                seen++;
                b.idx  = i;
                b.val  = stim[i];
                b.last = (seen == nz) ? 1 : 0;
                exp_q.push_back(b);
            end
        end
        exp_nz_q.push_back(nz);
        $display("[%0d] vector issued len=%0d nonzero=%0d", cyc, stim.size(), nz);
    endtask

    task automatic send_vec(input bit use_last, input bit gaps);
        bit got;
        push_model();
        for (int i = 0; i < stim.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                sif.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            sif.in_valid = 1'b1;
            sif.in_data  = DW'(stim[i]);
            sif.in_last  = use_last && (i == stim.size() - 1);
            got = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge clk);
                got = sif.in_ready && ena;
                @(posedge clk); #1;
            end
            if (!got) fail_now("accept_timeout");
        end
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
        sif.in_data  = '0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || exp_nz_q.size() != 0) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 2000) fail_now("drain_timeout");
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: beats, vec_done, handshake stability and ena gating.
    bit          hold_pending = 0;
    logic [31:0] hold_word;
    int          mon_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 0;
            mon_cnt      = 0;
        end else if (!ena) begin
            chk("ena_low_gating", {sif.out_valid, sif.in_ready}, 0);
        end else begin
            if (hold_pending) begin
                chk("hold_valid", sif.out_valid, 1);
                chk("hold_stable", {sif.out_last, sif.out_index, sif.out_value}, hold_word);
                hold_pending = 0;
            end
            if (sif.out_valid) begin
                if (!sif.out_ready) begin
                    hold_pending = 1;
                    hold_word    = 32'({sif.out_last, sif.out_index, sif.out_value});
                end else begin
                    $display("[%0d] beat idx=%0d val=%0d last=%0d", cyc, sif.out_index,
                             sif.out_value, sif.out_last);
                    beat_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        chk("beat_idx", sif.out_index, e.idx);
                        chk("beat_val", sif.out_value, e.val);
                        chk("beat_last", sif.out_last, e.last);
                    end
                end
            end
            if (sif.vec_done) begin
                $display("[%0d] vec_done nz_count=%0d", cyc, sif.nz_count);
                done_cyc = cyc;
                if (exp_nz_q.size() == 0) chk("unexpected_vec_done", 1, 0);
                else chk("nz_count", sif.nz_count, exp_nz_q.pop_front());
            end
            if (sif.in_valid && sif.in_ready) begin
                if (sif.in_last || mon_cnt == VL - 1) begin
                    acc_cyc = cyc;
                    mon_cnt = 0;
                end else begin
                    mon_cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) sif.out_ready = ($urandom_range(0, 3) != 0);
            if (rand_ena) ena = ($urandom_range(0, 7) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        ena           = 1'b1;
        sif.in_data   = '0;
        sif.in_valid  = 1'b0;
        sif.in_last   = 1'b0;
        sif.out_ready = 1'b1;
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_outputs", {sif.out_valid, sif.out_last, sif.out_index, sif.out_value,
                              sif.vec_done, sif.nz_count}, 0);
        chk("reset_in_ready", sif.in_ready, 1);
        @(posedge clk); #1;

        // Sparse vector with explicit last, consumer always ready.
        beat_cyc_q.delete();
        stim = '{0, 5, 0, 0, 9, 0, 0, 3};
        send_vec(1'b1, 1'b0);
        drain();
        chk("t1_nbeats", beat_cyc_q.size(), 3);
        if (beat_cyc_q.size() == 3) begin
            chk("t1_first_latency", beat_cyc_q[0] - acc_cyc, 1);
            chk("t1_back_to_back", beat_cyc_q[2] - beat_cyc_q[0], 2);
            chk("t1_done_latency", done_cyc - beat_cyc_q[2], 1);
        end

        // All-zero vector skips EMIT entirely.
        stim = '{0, 0, 0, 0};
        send_vec(1'b1, 1'b0);
        @(negedge clk);
        chk("t2_vec_done", sif.vec_done, 1);
        chk("t2_in_ready", sif.in_ready, 1);
        chk("t2_no_valid", sif.out_valid, 0);
        @(posedge clk); #1;
        drain();

        // Back-pressure on the first beat.
        sif.out_ready = 1'b0;
        stim = '{7, 8};
        send_vec(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_held", {sif.out_valid, sif.out_index, sif.out_value}, {1'b1, 3'd0, 8'd7});
            @(posedge clk); #1;
        end
        sif.out_ready = 1'b1;
        drain();

        // Full length without in_last.
        stim = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_vec(1'b0, 1'b0);
        drain();

        // ena dropped mid-EMIT after the first beat.
        stim = '{0, 4, 6};
        send_vec(1'b1, 1'b0);
        @(posedge clk); #1;
        ena = 1'b0;
        idle(3);
        ena = 1'b1;
        @(negedge clk);
        chk("t5_resume", {sif.out_valid, sif.out_index, sif.out_value, sif.out_last},
            {1'b1, 3'd2, 8'd6, 1'b1});
        @(posedge clk); #1;
        drain();

        // Asynchronous reset in the middle of EMIT.
        sif.out_ready = 1'b0;
        stim = '{1, 2, 3};
        send_vec(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", {sif.out_valid, sif.out_last, sif.out_index, sif.out_value,
                               sif.vec_done, sif.nz_count}, 0);
        exp_q.delete();
        exp_nz_q.delete();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        sif.out_ready = 1'b1;
        idle(5);
        stim = '{0, 9};
        send_vec(1'b1, 1'b0);
        drain();

        // Randomized traffic with random back-pressure, enable drops and input gaps.
        rand_rdy = 1;
        rand_ena = 1;
        for (int v = 0; v < 40; v++) begin
            int len;
            bit use_last;
            len = $urandom_range(1, VL);
            stim.delete();
            for (int i = 0; i < len; i++) begin
                stim.push_back(($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 255)) : 0);
            end
            use_last = (len < VL) ? 1'b1 : 1'($urandom_range(0, 1));
            send_vec(use_last, 1'b1);
        end
        rand_ena = 0;
        rand_rdy = 0;
        @(posedge clk); #1;
        ena = 1'b1;
        sif.out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
